reg_bank_dbg: RTL and testbench

//  Parametrised MIPS general-purpose register bank: NRD combinational read ports, one write port, optional hardwired-zero r0 and write-to-read bypass.

---
 rtl/reg_bank_pkg.sv | 29 ++
 rtl/reg_bank_dump_fsm.sv | 96 +++++++++
 rtl/reg_bank_dbg.sv | 90 +++++++++
 tb/tb_reg_bank_dbg.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared definitions for the MIPS register bank: default sizes, dump FSM
// states and the write-hit rule used by every read port.
package reg_bank_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_NREGS  = 32;
    localparam int ADDR_MAX   = 16;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } dumpState_t;

    // True when a write lands in the array and targets raddr; out-of-range
    // writes and (optionally) r0 writes never hit anything.
    function automatic logic wr_hit(
        input logic                we,
        input logic [ADDR_MAX-1:0] waddr,
        input logic [ADDR_MAX-1:0] raddr,
        input int                  nregs,
        input logic                zeroReg
    );
        logic dropped;
        dropped = (int'(waddr) >= nregs) || (zeroReg && (waddr == '0));
        return we && !dropped && (waddr == raddr);
    endfunction

endpackage

// File: rtl/reg_bank_dump_fsm.sv
// Debug dump engine: walks the register bank one beat per handshake,
// holding each beat's address/data stable until the consumer accepts it.
module reg_bank_dump_fsm
    import reg_bank_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREGS  = DEF_NREGS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_dump_start,
    input  logic              i_dump_ready,
    input  logic [DATA_W-1:0] i_rdData,
    output logic [ADDR_W-1:0] o_rdAddr,
    output logic              o_dump_valid,
    output logic [ADDR_W-1:0] o_dump_addr,
    output logic [DATA_W-1:0] o_dump_data,
    output logic              o_dump_last,
    output logic              o_busy
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

    dumpState_t        r_state;
    dumpState_t        w_nextState;
    logic [ADDR_W-1:0] r_ptr;
    logic [DATA_W-1:0] r_data;
    logic              r_last;
    logic [ADDR_W-1:0] w_nextPtr;
    logic              w_start;
    logic              w_advance;
    logic              w_finish;

    assign w_nextPtr = r_ptr + ADDR_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (i_dump_start) w_nextState = SEND;
            SEND:    if (i_dump_ready && r_last) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // The array read address is only meaningful on a load cycle; at start it
    // is r0, on an accepted non-final beat it is the next register.
    always_comb begin
        o_dump_valid = 1'b0;
        o_busy       = 1'b0;
        w_start      = 1'b0;
        w_advance    = 1'b0;
        w_finish     = 1'b0;
        o_rdAddr     = '0;
        if (r_state == SEND) begin
            o_dump_valid = 1'b1;
            o_busy       = 1'b1;
            w_advance    = i_dump_ready && !r_last;
            w_finish     = i_dump_ready && r_last;
        end else begin
            w_start = i_dump_start;
        end
        if (w_advance) o_rdAddr = w_nextPtr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr  <= '0;
            r_data <= '0;
            r_last <= 1'b0;
        end else if (w_start) begin
            r_ptr  <= '0;
            r_data <= i_rdData;
            r_last <= (LAST_IDX == '0);
        end else if (w_advance) begin
            r_ptr  <= w_nextPtr;
            r_data <= i_rdData;
            r_last <= (w_nextPtr == LAST_IDX);
        end else if (w_finish) begin
            r_last <= 1'b0;
        end
    end

    assign o_dump_addr = r_ptr;
    assign o_dump_data = r_data;
    assign o_dump_last = r_last;

endmodule

// File: rtl/reg_bank_dbg.sv
// MIPS general-purpose register bank with NRD combinational read ports, one
// write port, optional hardwired r0 and write bypass, plus a debug dump port.
module reg_bank_dbg
    import reg_bank_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NREGS    = DEF_NREGS,
    parameter int NRD      = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_waddr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [NRD*ADDR_W-1:0] i_raddr,
    output logic [NRD*DATA_W-1:0] o_rdata,
    input  logic                  i_dump_start,
    input  logic                  i_dump_ready,
    output logic                  o_dump_valid,
    output logic [ADDR_W-1:0]     o_dump_addr,
    output logic [DATA_W-1:0]     o_dump_data,
    output logic                  o_dump_last,
    output logic                  o_busy
);

    localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [DATA_W-1:0] r_regs [NREGS];
    logic              w_wrEn;
    logic [ADDR_W-1:0] w_dumpAddr;
    logic [DATA_W-1:0] w_dumpData;

    assign w_wrEn = wr_hit(i_we, ADDR_MAX'(i_waddr), ADDR_MAX'(i_waddr), NREGS, ZERO_REG);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (w_wrEn) begin
            r_regs[i_waddr[IDX_W-1:0]] <= i_wdata;
        end
    end

    // Ports 0..NRD-1 are external; port NRD feeds the dump engine and always
    // forwards a same-cycle write so a beat captures the freshest value.
    for (genvar k = 0; k <= NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_data;

        if (k < NRD) begin : g_ext
            assign w_addr = i_raddr[k*ADDR_W +: ADDR_W];
            assign o_rdata[k*DATA_W +: DATA_W] = w_data;
        end else begin : g_dump
            assign w_addr     = w_dumpAddr;
            assign w_dumpData = w_data;
        end

        always_comb begin
            w_data = '0;
            if ((int'(w_addr) < NREGS) && !(ZERO_REG && (w_addr == '0))) begin
                w_data = r_regs[w_addr[IDX_W-1:0]];
            end
            if (((k == NRD) || BYPASS) &&
                wr_hit(i_we, ADDR_MAX'(i_waddr), ADDR_MAX'(w_addr), NREGS, ZERO_REG)) begin
                w_data = i_wdata;
            end
        end
    end

    reg_bank_dump_fsm #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_dump (
        .clk          (clk),
        .reset        (reset),
        .i_dump_start (i_dump_start),
        .i_dump_ready (i_dump_ready),
        .i_rdData     (w_dumpData),
        .o_rdAddr     (w_dumpAddr),
        .o_dump_valid (o_dump_valid),
        .o_dump_addr  (o_dump_addr),
        .o_dump_data  (o_dump_data),
        .o_dump_last  (o_dump_last),
        .o_busy       (o_busy)
    );

endmodule

// File: tb/tb_reg_bank_dbg.sv
// Self-checking bench: a 32-register bypassed bank and a 16-register,
// 4-port, non-bypassed bank share the write port and are checked against arrays.
module tb_reg_bank_dbg;

    logic         clk;
    logic         reset;
    logic         we;
    logic [4:0]   waddr;
    logic [31:0]  wdata;
    logic [9:0]   raddrA;
    logic [63:0]  rdataA;
    logic [19:0]  raddrB;
    logic [127:0] rdataB;
    logic         startA, readyA, validA, lastA, busyA;
    logic [4:0]   addrA;
    logic [31:0]  dataA;
    logic         startB, readyB, validB, lastB, busyB;
    logic [4:0]   addrB;
    logic [31:0]  dataB;

    logic [31:0]  modelA [32];
    logic [31:0]  modelB [16];
    int           testCount = 0;
    int           failCount = 0;

    reg_bank_dbg #(
        .ADDR_W(5), .DATA_W(32), .NREGS(32), .NRD(2), .ZERO_REG(1'b1), .BYPASS(1'b1)
    ) dutA (
        .clk(clk), .reset(reset), .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
        .i_raddr(raddrA), .o_rdata(rdataA),
        .i_dump_start(startA), .i_dump_ready(readyA), .o_dump_valid(validA),
        .o_dump_addr(addrA), .o_dump_data(dataA), .o_dump_last(lastA), .o_busy(busyA)
    );

    reg_bank_dbg #(
        .ADDR_W(5), .DATA_W(32), .NREGS(16), .NRD(4), .ZERO_REG(1'b1), .BYPASS(1'b0)
    ) dutB (
        .clk(clk), .reset(reset), .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
        .i_raddr(raddrB), .o_rdata(rdataB),
        .i_dump_start(startB), .i_dump_ready(readyB), .o_dump_valid(validB),
        .o_dump_addr(addrB), .o_dump_data(dataB), .o_dump_last(lastB), .o_busy(busyB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic w, input logic [4:0] a, input logic [31:0] d);
        we    = w;
        waddr = a;
        wdata = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Architectural register view: r0 and unimplemented registers read 0,
    // a same-cycle write is visible only where forwarding is enabled.
    function automatic logic [31:0] refRead(input int which, input int addr, input bit byp);
        int n;
        n = which ? 16 : 32;
        if (addr >= n || addr == 0) return 32'h0;
        if (byp && we && int'(waddr) == addr) return wdata;
        return which ? modelB[addr] : modelA[addr];
    endfunction

    task automatic commitWrite();
        if (we && waddr != 5'd0) begin
            modelA[waddr] = wdata;
            if (waddr < 5'd16) modelB[waddr[3:0]] = wdata;
        end
    endtask

    task automatic clearModels();
        for (int i = 0; i < 32; i++) modelA[i] = 32'h0;
        for (int i = 0; i < 16; i++) modelB[i] = 32'h0;
    endtask

    task automatic checkReads();
        for (int k = 0; k < 2; k++)
            checkOutput($sformatf("rdA%0d", k), rdataA[k*32 +: 32], refRead(0, int'(raddrA[k*5 +: 5]), 1'b1));
        for (int k = 0; k < 4; k++)
            checkOutput($sformatf("rdB%0d", k), rdataB[k*32 +: 32], refRead(1, int'(raddrB[k*5 +: 5]), 1'b0));
    endtask

    // One complete dump on bank A (which=0) or B (which=1); each beat must
    // carry the register value as it stood when that beat was loaded.
    task automatic runDump(input int which, input bit randReady, input bit randWrites, input int abortAt);
        int          n;
        int          curIdx;
        int          beats;
        int          cycles;
        bit          inSend;
        bit          done;
        bit          aborted;
        bit          rdy;
        bit          startNow;
        logic [31:0] held;
        logic        v, b, l;
        logic [4:0]  a;
        logic [31:0] d;
        n = which ? 16 : 32;
        curIdx = 0; beats = 0; cycles = 0;
        inSend = 0; done = 0; aborted = 0; held = 32'h0;
        while (!done && cycles < 400) begin
            startNow = (cycles == 0);
            rdy = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            if (which != 0) begin startB = startNow; readyB = rdy; end
            else            begin startA = startNow; readyA = rdy; end
            if (randWrites) begin
                if (inSend && !rdy && $urandom_range(0, 1) == 1)
                    applyStimulus(1'b1, 5'(curIdx), $urandom);
                else
                    applyStimulus($urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)), $urandom);
            end else begin
                applyStimulus(1'b0, 5'd0, 32'h0);
            end
            #4;
            v = which ? validB : validA;
            b = which ? busyB  : busyA;
            l = which ? lastB  : lastA;
            a = which ? addrB  : addrA;
            d = which ? dataB  : dataA;
            checkOutput("dumpValid", 32'(v), 32'(inSend));
            checkOutput("dumpBusy", 32'(b), 32'(inSend));
            if (inSend) begin
                checkOutput("dumpAddr", 32'(a), 32'(curIdx));
                checkOutput("dumpData", d, held);
                checkOutput("dumpLast", 32'(l), 32'(curIdx == n - 1));
            end
            if (inSend && curIdx == abortAt) begin
                reset = 1'b1;
                we = 1'b0;
                raddrA = {5'd7, 5'd3};
                #1;
                checkOutput("abortValid", 32'(validA), 32'h0);
                checkOutput("abortBusy", 32'(busyA), 32'h0);
                checkOutput("abortLast", 32'(lastA), 32'h0);
                checkOutput("abortRd0", rdataA[31:0], 32'h0);
                checkOutput("abortRd1", rdataA[63:32], 32'h0);
                clearModels();
                step();
                reset = 1'b0;
                aborted = 1;
                done = 1;
            end else begin
                if (!inSend && startNow) begin
                    held = refRead(which, 0, 1'b1);
                    curIdx = 0;
                    inSend = 1;
                end else if (inSend && rdy) begin
                    beats++;
                    if (curIdx == n - 1) begin
                        inSend = 0;
                        done = 1;
                    end else begin
                        curIdx++;
                        held = refRead(which, curIdx, 1'b1);
                    end
                end
                commitWrite();
                step();
                cycles++;
            end
        end
        startA = 1'b0; startB = 1'b0; readyA = 1'b0; readyB = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'h0);
        checkOutput("dumpTimeout", 32'(done), 32'h1);
        if (!aborted) begin
            #4;
            checkOutput("dumpBeats", 32'(beats), 32'(n));
            checkOutput("endValid", 32'(which ? validB : validA), 32'h0);
            checkOutput("endBusy", 32'(which ? busyB : busyA), 32'h0);
            checkOutput("endLast", 32'(which ? lastB : lastA), 32'h0);
            step();
        end
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'h0);
        raddrA = '0; raddrB = '0;
        startA = 1'b0; readyA = 1'b0; startB = 1'b0; readyB = 1'b0;
        clearModels();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstValidA", 32'(validA), 32'h0);
        checkOutput("rstBusyA", 32'(busyA), 32'h0);
        checkOutput("rstLastA", 32'(lastA), 32'h0);
        checkOutput("rstAddrA", 32'(addrA), 32'h0);
        checkOutput("rstDataA", dataA, 32'h0);
        checkOutput("rstValidB", 32'(validB), 32'h0);
        checkOutput("rstBusyB", 32'(busyB), 32'h0);
        checkOutput("rstDataB", dataB, 32'h0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 32; i++) begin
            raddrA = {5'(i), 5'(i)};
            raddrB = {5'(i), 5'(i), 5'(i), 5'(i)};
            #1;
            checkOutput("rstReadA", rdataA[31:0], 32'h0);
            checkOutput("rstReadB", rdataB[127:96], 32'h0);
        end
        step();

        raddrA = '0; raddrB = '0;
        applyStimulus(1'b1, 5'd0, 32'hDEAD);
        #4; checkReads(); commitWrite(); step();
        applyStimulus(1'b0, 5'd0, 32'h0);
        #4; checkOutput("r0AfterWrite", rdataA[31:0], 32'h0);
        step();

        raddrA = {5'd0, 5'd5};
        raddrB = {15'd0, 5'd5};
        applyStimulus(1'b1, 5'd5, 32'h1234);
        #4;
        checkOutput("bypassA", rdataA[31:0], 32'h1234);
        checkOutput("noBypassB", rdataB[31:0], 32'h0);
        commitWrite(); step();
        applyStimulus(1'b0, 5'd0, 32'h0);
        #4;
        checkOutput("storedA", rdataA[31:0], 32'h1234);
        checkOutput("storedB", rdataB[31:0], 32'h1234);
        step();

        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
            raddrA = 10'($urandom);
            raddrB = 20'($urandom);
            #4; checkReads(); commitWrite(); step();
        end

        for (int i = 1; i < 32; i++) begin
            applyStimulus(1'b1, 5'(i), 32'(i * 3));
            commitWrite(); step();
        end
        applyStimulus(1'b0, 5'd0, 32'h0);
        runDump(0, 1'b0, 1'b0, -1);
        runDump(0, 1'b1, 1'b1, -1);
        runDump(0, 1'b0, 1'b0, 10);
        runDump(0, 1'b1, 1'b1, -1);

        raddrB = {15'd0, 5'd20};
        raddrA = {5'd0, 5'd20};
        applyStimulus(1'b1, 5'd20, 32'hCAFE);
        #4; checkReads(); commitWrite(); step();
        applyStimulus(1'b0, 5'd0, 32'h0);
        #4;
        checkOutput("dropB20", rdataB[31:0], 32'h0);
        checkOutput("keepA20", rdataA[31:0], 32'hCAFE);
        step();
        runDump(1, 1'b0, 1'b0, -1);
        runDump(1, 1'b1, 1'b1, -1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
